count_seq_checker: RTL and testbench

- Consumer-side monitor for the mod-N count stream produced by the design's wrapping counters (sequence 0,1,...,MODULUS-1,0,...).
- Synchronises to the incoming count, verifies every sampled value against the expected successor, and reports sequence errors and wrap events.
- Keeps saturating statistics counters.
- Sits on the receive side of any counter output that leaves its clock-enable domain.

---
 rtl/count_seq_checker.sv | 129 ++++++++++++
 tb/tb_count_seq_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side monitor for a mod-MODULUS count stream.
// Locks onto the incoming count, flags sequence breaks and legal wraps,
// and keeps saturating error/wrap statistics.
module count_seq_checker #(
  parameter int unsigned MODULUS    = 11,
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned STAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clear,
  output logic                  locked,
  output logic                  seq_err,
  output logic                  wrap_pulse,
  output logic [STAT_WIDTH-1:0] err_count,
  output logic [STAT_WIDTH-1:0] wrap_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [WIDTH-1:0]      LAST_VAL    = WIDTH'(MODULUS - 1);
  localparam logic [MATCH_W-1:0]    LOCK_TARGET = MATCH_W'(LOCK_CNT);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX    = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [WIDTH-1:0]        expected, expected_n;
  logic [MATCH_W-1:0]      match, match_n;
  logic                    locked_n, seq_err_n, wrap_n;
  logic [STAT_WIDTH-1:0]   err_count_n, wrap_count_n;
  logic                    in_range_c;

  // Successor in the mod-MODULUS sequence.
  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] x);
    return (x == LAST_VAL) ? '0 : x + WIDTH'(1);
  endfunction

  // Legal count values are 0..MODULUS-1 (always true when MODULUS == 2^WIDTH).
  assign in_range_c = ((WIDTH+1)'(count_in) < (WIDTH+1)'(MODULUS));

  // State register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      expected   <= '0;
      match      <= '0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_n;
      expected   <= expected_n;
      match      <= match_n;
      locked     <= locked_n;
      seq_err    <= seq_err_n;
      wrap_pulse <= wrap_n;
      err_count  <= err_count_n;
      wrap_count <= wrap_count_n;
    end
  end

  // Next-state, sequence check and statistics update.
  always_comb begin
    state_n      = state;
    expected_n   = expected;
    match_n      = match;
    seq_err_n    = 1'b0;
    wrap_n       = 1'b0;
    err_count_n  = err_count;
    wrap_count_n = wrap_count;

    if (sample_en) begin
      unique case (state)
        HUNT: begin
          if (in_range_c) begin
            expected_n = succ(count_in);
            match_n    = '0;
            state_n    = VERIFY;
          end
        end
        VERIFY: begin
          if (count_in == expected) begin
            expected_n = succ(expected);
            match_n    = match + MATCH_W'(1);
            if (match_n == LOCK_TARGET) state_n = LOCKED;
          end else if (in_range_c) begin
            expected_n = succ(count_in);
            match_n    = '0;
          end else begin
            state_n = HUNT;
          end
        end
        LOCKED: begin
          if (count_in == expected) begin
            expected_n = succ(expected);
            wrap_n     = (count_in == '0);
          end else begin
            seq_err_n = 1'b1;
            state_n   = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end

    locked_n = (state_n == LOCKED);

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    if (clear) begin
      err_count_n  = '0;
      wrap_count_n = '0;
    end else begin
      if (seq_err_n && (err_count != STAT_MAX))
        err_count_n = err_count + STAT_WIDTH'(1);
      if (wrap_n && (wrap_count != STAT_MAX))
        wrap_count_n = wrap_count + STAT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Testbench for count_seq_checker: directed scenarios plus randomized stream
// against a behavioural model of the stream rules.
module tb_count_seq_checker;

  localparam int MOD  = 11;
  localparam int LOCK = 3;
  localparam int SMAX = 255;

  logic       clk;
  logic       reset;
  logic       sample_en;
  logic [3:0] count_in;
  logic       clear;
  logic       locked, seq_err, wrap_pulse;
  logic [7:0] err_count, wrap_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: tracked value, run of correct successors, lock flag.
  bit m_locked, m_err, m_wrap, m_tracking;
  int m_exp, m_run, m_errc, m_wrapc;

  count_seq_checker #(.MODULUS(11), .WIDTH(4), .LOCK_CNT(3), .STAT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .count_in(count_in),
    .clear(clear), .locked(locked), .seq_err(seq_err), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_locked = 0; m_err = 0; m_wrap = 0; m_tracking = 0;
    m_exp = 0; m_run = 0; m_errc = 0; m_wrapc = 0;
  endfunction

  function automatic void model_apply(input bit en, input int v, input bit clr);
    m_err = 0;
    m_wrap = 0;
    if (en) begin
      if (m_locked) begin
        if (v == m_exp) begin
          m_wrap = (v == 0);
          m_exp = (v + 1) % MOD;
        end else begin
          m_err = 1; m_locked = 0; m_tracking = 0;
        end
      end else if (m_tracking && v == m_exp) begin
        m_run++;
        m_exp = (v + 1) % MOD;
        if (m_run >= LOCK) m_locked = 1;
      end else if (v < MOD) begin
        m_tracking = 1; m_run = 0; m_exp = (v + 1) % MOD;
      end else begin
        m_tracking = 0;
      end
    end
    if (clr) begin
      m_errc = 0; m_wrapc = 0;
    end else begin
      if (m_err && m_errc < SMAX) m_errc++;
      if (m_wrap && m_wrapc < SMAX) m_wrapc++;
    end
  endfunction

  function automatic logic [18:0] model_vec();
    return {m_locked, m_err, m_wrap, 8'(m_errc), 8'(m_wrapc)};
  endfunction

  // Apply one cycle of input, then advance the model; outputs are valid #1 after the edge.
  task automatic drive(input bit en, input int v, input bit clr);
    sample_en = en;
    count_in  = 4'(v);
    clear     = clr;
    @(posedge clk);
    #1;
    model_apply(en, v, clr);
  endtask

  task automatic test_reset();
    reset = 1; sample_en = 0; count_in = '0; clear = 0;
    #2 reset = 0;
    #1;
    checks++;
    if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== 19'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {locked, seq_err, wrap_pulse, err_count, wrap_count}, 19'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== 19'd0) begin
      failures++;
      $display("FAIL reset_held got=%h exp=%h", {locked, seq_err, wrap_pulse, err_count, wrap_count}, 19'd0);
    end
    @(negedge clk) reset = 1;
    model_reset();
  endtask

  task automatic test_lock();
    int seq[4] = '{5, 6, 7, 8};
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL lock step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL lock_after_8 locked=%b err_count=%0d exp locked=1 err_count=0", locked, err_count);
    end
  endtask

  task automatic test_wrap();
    int seq[4] = '{9, 10, 0, 1};
    for (int i = 0; i < 4; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL wrap step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
      if (i == 2) begin
        checks++;
        if (wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || locked !== 1'b1) begin
          failures++;
          $display("FAIL wrap_after_0 wrap_pulse=%b wrap_count=%0d locked=%b exp 1/1/1", wrap_pulse, wrap_count, locked);
        end
      end
    end
  endtask

  task automatic test_seq_error();
    int seq[5] = '{4, 4, 5, 6, 7};
    for (int i = 0; i < 5; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL seq_error step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
      if (i == 0) begin
        checks++;
        if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
          failures++;
          $display("FAIL err_pulse seq_err=%b locked=%b err_count=%0d exp 1/0/1", seq_err, locked, err_count);
        end
      end
    end
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL relock locked=%b err_count=%0d exp 1/1", locked, err_count);
    end
  endtask

  task automatic test_out_of_range();
    int seq[8] = '{12, 12, 14, 2, 3, 4, 5, 15};
    for (int i = 0; i < 8; i++) begin
      drive(1, seq[i], 0);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL out_of_range step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
      if (i == 2) begin
        checks++;
        if (seq_err !== 1'b0 || locked !== 1'b0) begin
          failures++;
          $display("FAIL hunt_oor seq_err=%b locked=%b exp 0/0", seq_err, locked);
        end
      end
    end
    checks++;
    if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd3) begin
      failures++;
      $display("FAIL locked_oor seq_err=%b locked=%b err_count=%0d exp 1/0/3", seq_err, locked, err_count);
    end
  endtask

  task automatic test_gaps();
    bit en[7] = '{1, 0, 1, 0, 0, 1, 1};
    int val[7] = '{3, 9, 4, 1, 2, 5, 6};
    for (int i = 0; i < 7; i++) begin
      drive(en[i], val[i], 0);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL gaps step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL gaps_lock locked=%b exp 1", locked);
    end
    drive(1, 7, 0);
    #2 reset = 0;
    #1;
    checks++;
    if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== 19'd0) begin
      failures++;
      $display("FAIL reset_midstream got=%h exp=%h", {locked, seq_err, wrap_pulse, err_count, wrap_count}, 19'd0);
    end
    @(negedge clk) reset = 1;
    model_reset();
  endtask

  task automatic test_random();
    int src = $urandom_range(0, MOD - 1);
    for (int i = 0; i < 400; i++) begin
      bit en = ($urandom_range(0, 3) != 0);
      bit clr = ($urandom_range(0, 49) == 0);
      int v = ($urandom_range(0, 9) != 0) ? src : $urandom_range(0, 15);
      if (en && v < MOD) src = (v + 1) % MOD;
      drive(en, v, clr);
      checks++;
      if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
        failures++;
        $display("FAIL random step=%0d got=%h exp=%h", i, {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int seq[5] = '{0, 1, 2, 3, 7};
    int bad = 0;
    drive(0, 0, 1);
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 5; i++) begin
        drive(1, seq[i], 0);
        if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL saturation_stream mismatches=%0d exp 0", bad);
    end
    checks++;
    if (err_count !== 8'd255 || seq_err !== 1'b1) begin
      failures++;
      $display("FAIL saturate err_count=%0d seq_err=%b exp 255/1", err_count, seq_err);
    end
    for (int i = 0; i < 4; i++) drive(1, seq[i], 0);
    drive(1, 7, 1);
    checks++;
    if (err_count !== 8'd0 || seq_err !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("FAIL clear_vs_err err_count=%0d seq_err=%b locked=%b exp 0/1/0", err_count, seq_err, locked);
    end
    checks++;
    if ({locked, seq_err, wrap_pulse, err_count, wrap_count} !== model_vec()) begin
      failures++;
      $display("FAIL clear_model got=%h exp=%h", {locked, seq_err, wrap_pulse, err_count, wrap_count}, model_vec());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_wrap();
    test_seq_error();
    test_out_of_range();
    test_gaps();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
